reset_request_gen: RTL

- Source-side companion to the reset crossing FIFO: collects reset requests from several local sources and issues single-cycle reset pulses into the crossing's write side.
- Requests are rising-edge detected and maskable.
- Each issued pulse also drives a stretched local reset.
- A holdoff window rate-limits pulses so the downstream bit-stream FIFO is never flooded; requests arriving during a busy window are merged into one follow-up pulse.

---
 rtl/reset_request_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reset_request_gen.sv
// Collects edge-detected, maskable reset requests and issues rate-limited single-cycle
// pulses plus a stretched local reset. Requests seen while busy merge into one follow-up pulse.
module reset_request_gen #(
    parameter int NSRC           = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    output logic            pulse_out,
    output logic            rst_local,
    output logic            busy,
    output logic [NSRC-1:0] cause,
    output logic [7:0]      pulse_count
);

    localparam int MAXC = (HOLD_CYCLES > HOLDOFF_CYCLES) ? HOLD_CYCLES : HOLDOFF_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD, HOLDOFF} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] req_q, req_qq;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pulse_out_q, pulse_out_d;
    logic            rst_local_q, rst_local_d;
    logic            busy_q, busy_d;
    logic [NSRC-1:0] req_edge;
    logic [NSRC-1:0] merged;

    always_comb begin
        req_edge    = req_q & ~req_qq & ~mask;
        merged      = pending_q | req_edge;
        state_d     = state_q;
        pending_d   = pending_q;
        cause_d     = cause_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        // Outputs are registered images of the current state, one cycle behind it.
        pulse_out_d = (state_q == PULSE);
        rst_local_d = (state_q == PULSE) || (state_q == HOLD);
        busy_d      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (|req_edge) begin
                    cause_d = req_edge;
                    state_d = PULSE;
                end
            end
            PULSE: begin
                pending_d = merged;
                if (count_q != 8'hFF) count_d = count_q + 8'd1;
                if (HOLD_CYCLES == 1) begin
                    cnt_d   = HOLDOFF_LOAD;
                    state_d = HOLDOFF;
                end else begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                pending_d = merged;
                // PULSE already supplied one rst_local cycle, so HOLD leaves one count early.
                if (cnt_q == CW'(1)) begin
                    cnt_d   = HOLDOFF_LOAD;
                    state_d = HOLDOFF;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    pending_d = '0;
                    if (|merged) begin
                        cause_d = merged;
                        state_d = PULSE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pending_d = merged;
                    cnt_d     = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_qq      <= '0;
            pending_q   <= '0;
            cause_q     <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            pulse_out_q <= 1'b0;
            rst_local_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req;
            req_qq      <= req_q;
            pending_q   <= pending_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            pulse_out_q <= pulse_out_d;
            rst_local_q <= rst_local_d;
            busy_q      <= busy_d;
        end
    end

    assign pulse_out   = pulse_out_q;
    assign rst_local   = rst_local_q;
    assign busy        = busy_q;
    assign cause       = cause_q;
    assign pulse_count = count_q;

endmodule
